// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the I/D-cache main-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on a tie the requester not served last wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
        else                grant_id = req_d ? REQ_D : REQ_I;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache memory ports onto one memory port;
// the winning request is latched and replayed until memory acknowledges.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_i_q, rbuf_d_q;

    logic              load;
    logic              cap_i, cap_d;
    logic              pick_valid, pick_id;

    rr_pick2 u_pick (
        .req_i       (i_mem_read | i_mem_write),
        .req_d       (d_mem_read | d_mem_write),
        .last_grant  (last_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= REQ_I;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_i_q <= '0;
            rbuf_d_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            // write wins over read when a cache raises both
            if (load) begin
                wr_q    <= (pick_id == REQ_D) ? d_mem_write : i_mem_write;
                addr_q  <= (pick_id == REQ_D) ? d_mem_addr  : i_mem_addr;
                wdata_q <= (pick_id == REQ_D) ? d_mem_wdata : i_mem_wdata;
            end
            if (cap_i) rbuf_i_q <= mem_rdata;
            if (cap_d) rbuf_d_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        load    = 1'b0;
        cap_i   = 1'b0;
        cap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = (pick_id == REQ_D) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I: begin
                if (mem_ready) begin
                    cap_i   = 1'b1;
                    last_d  = REQ_I;
                    state_d = ST_DONE_I;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    cap_d   = 1'b1;
                    last_d  = REQ_D;
                    state_d = ST_DONE_D;
                end
            end
            ST_DONE_I, ST_DONE_D: state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        case (state_q)
            ST_BUSY_I, ST_BUSY_D: begin
                mem_read  = ~wr_q;
                mem_write = wr_q;
            end
            ST_DONE_I: i_mem_ready = 1'b1;
            ST_DONE_D: d_mem_ready = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_mem_rdata = rbuf_i_q;
    assign d_mem_rdata = rbuf_d_q;

endmodule
